// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and the control unit.
// Holds the default datapath widths, the 4-bit opcode map and the
// fetch sequencer state type.
package cpu_pkg;

  localparam int INST_W = 8;
  localparam int PC_W   = 8;
  localparam int OPC_W  = 4;

  localparam logic [OPC_W-1:0] OPC_MOVE  = 4'b0000;
  localparam logic [OPC_W-1:0] OPC_ADD   = 4'b0001;
  localparam logic [OPC_W-1:0] OPC_SUB   = 4'b0010;
  localparam logic [OPC_W-1:0] OPC_AND   = 4'b0011;
  localparam logic [OPC_W-1:0] OPC_OR    = 4'b0100;
  localparam logic [OPC_W-1:0] OPC_XOR   = 4'b0101;
  localparam logic [OPC_W-1:0] OPC_SHL   = 4'b0110;
  localparam logic [OPC_W-1:0] OPC_SHR   = 4'b0111;
  localparam logic [OPC_W-1:0] OPC_LD    = 4'b1000;
  localparam logic [OPC_W-1:0] OPC_ST    = 4'b1001;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 4'b1010;
  localparam logic [OPC_W-1:0] OPC_BNE   = 4'b1011;
  localparam logic [OPC_W-1:0] OPC_JAL   = 4'b1100;
  localparam logic [OPC_W-1:0] OPC_JR    = 4'b1101;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 4'b1110;
  localparam logic [OPC_W-1:0] OPC_LI    = 4'b1111;

  // FETCH: issue or hold a request. DROP: an outstanding request belongs
  // to a redirected-away path; its data is discarded when it returns.
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO buffering fetched {instruction, pc} entries.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   push, din      write an entry (ignored when full unless popping too)
//   pop            remove the head entry (ignored when empty)
//   flush          empty the FIFO; overrides push and pop
//   count          number of stored entries
//   full, empty    occupancy flags
//   head           oldest entry, straight from the storage registers
module fetch_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Storage is cleared on reset so the head reads zero out of reset;
  // pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  assign count = cnt;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the program counter, fetches instructions
// over a single-outstanding req/ack memory handshake, buffers them in a
// small FIFO and hands them to decode with valid/ready. A redirect flushes
// the buffer and retargets the PC; a request already on the bus is held
// until acked and its data dropped.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   imem_req, imem_addr    registered fetch request / address
//   imem_ack, imem_rdata   memory accept with same-cycle data
//   inst_valid, inst_ready decode handshake
//   instruction, inst_pc   head-of-buffer instruction and its PC
//   redirect_valid/_pc     taken branch or jump target (1-cycle pulse)
module fetch_unit #(
  parameter int              PC_W       = cpu_pkg::PC_W,
  parameter int              INST_W     = cpu_pkg::INST_W,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] instruction,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc
);

  import cpu_pkg::*;

  // FIFO_DEPTH must be a power of two and at least 2.
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = INST_W + PC_W;

  fetch_state_t      state, state_n;
  logic [PC_W-1:0]   fetch_pc, pc_n;
  logic [PC_W-1:0]   addr_q, addr_n;
  logic              req_q, req_n;
  logic              ack_fire;
  logic              hold;
  logic              push;
  logic              pop;
  logic              issue;
  logic [CW-1:0]     count, count_n;
  logic              full;
  logic              empty;
  logic [EW-1:0]     head;

  assign ack_fire = req_q && imem_ack;
  // An un-acked request keeps req/addr frozen, whatever else happens.
  assign hold     = req_q && !imem_ack;
  // Redirect wins: the same-cycle pop and any returning data are dropped.
  assign pop      = !empty && inst_ready && !redirect_valid;
  assign push     = (state == FETCH) && ack_fire && !redirect_valid && (!full || pop);

  always_comb begin
    state_n = state;
    pc_n    = fetch_pc;
    if (redirect_valid) begin
      pc_n    = redirect_pc;
      state_n = hold ? DROP : FETCH;
    end else if (state == FETCH) begin
      if (ack_fire) pc_n = fetch_pc + PC_W'(1);
    end else if (ack_fire) begin
      state_n = FETCH;
    end
  end

  // Occupancy after this cycle; a new request is issued only when a slot is
  // free for it, which reserves that slot until the data returns.
  always_comb begin
    count_n = count;
    if (redirect_valid) count_n = '0;
    else                count_n = count + CW'(push) - CW'(pop);
  end

  assign issue  = !hold && (state_n == FETCH) && (count_n < CW'(FIFO_DEPTH));
  assign req_n  = issue || hold;
  assign addr_n = issue ? pc_n : addr_q;

  // ---- request / PC register stage ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= pc_n;
      req_q    <= req_n;
      addr_q   <= addr_n;
    end
  end

  // ---- instruction buffer stage ----
  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .din     ({imem_rdata, fetch_pc}),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign inst_valid  = !empty;
  assign instruction = head[EW-1 -: INST_W];
  assign inst_pc     = head[PC_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic       inst_valid;
  logic       inst_ready;
  logic [7:0] instruction;
  logic [7:0] inst_pc;
  logic       redirect_valid;
  logic [7:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory image: every location holds its address XOR 0x5A.
  assign imem_rdata = imem_addr ^ 8'h5A;

  fetch_unit #(
    .PC_W       (8),
    .INST_W     (8),
    .RESET_PC   (8'h00),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instruction    (instruction),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of buffered {inst, pc}, the one outstanding
  // request, the next fetch address and whether the outstanding data is stale.
  logic [15:0] q[$];
  bit          m_req   = 1'b0;
  bit          m_drop  = 1'b0;
  bit          m_acked = 1'b0;
  logic [7:0]  m_pc    = 8'h00;
  logic [7:0]  m_addr  = 8'h00;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        q.delete();
        m_req  = 1'b0;
        m_drop = 1'b0;
        m_pc   = 8'h00;
        m_addr = 8'h00;
      end else begin
        m_acked = m_req && imem_ack;
        if (redirect_valid) begin
          q.delete();
          m_drop = m_req && !imem_ack;
          m_pc   = redirect_pc;
        end else begin
          if (q.size() > 0 && inst_ready) void'(q.pop_front());
          if (m_acked) begin
            if (m_drop) m_drop = 1'b0;
            else begin
              q.push_back({m_addr ^ 8'h5A, m_addr});
              m_pc = m_pc + 8'd1;
            end
          end
        end
        if (!(m_req && !imem_ack)) begin
          m_req  = !m_drop && (q.size() < 2);
          m_addr = m_pc;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        chk("model_req", 32'(imem_req), 32'(m_req));
        if (m_req) chk("model_addr", 32'(imem_addr), 32'(m_addr));
        chk("model_valid", 32'(inst_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
          chk("model_inst", 32'(instruction), 32'(q[0][15:8]));
          chk("model_pc", 32'(inst_pc), 32'(q[0][7:0]));
        end
      end
    end
  end

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic release_reset();
    #2 reset_n = 1'b1;
  endtask

  initial begin
    reset_n        = 1'b0;
    imem_ack       = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'h00);
    chk("rst_inst", 32'(instruction), 32'h00);
    chk("rst_pc", 32'(inst_pc), 32'h00);

    // Streaming: ack and ready tied high.
    imem_ack = 1'b1; inst_ready = 1'b1;
    release_reset();
    @(negedge clk);
    chk("t1_req", 32'(imem_req), 32'h1);
    chk("t1_addr", 32'(imem_addr), 32'h00);
    @(negedge clk);
    chk("t1_valid", 32'(inst_valid), 32'h1);
    chk("t1_inst0", 32'(instruction), 32'h5A);
    chk("t1_pc0", 32'(inst_pc), 32'h00);
    @(negedge clk);
    chk("t1_inst1", 32'(instruction), 32'h5B);
    chk("t1_pc1", 32'(inst_pc), 32'h01);
    repeat (4) @(negedge clk);

    // Back-pressure: buffer fills to two entries and requests stop.
    pulse_reset();
    imem_ack = 1'b1; inst_ready = 1'b0;
    release_reset();
    repeat (5) @(negedge clk);
    chk("t2_req_low", 32'(imem_req), 32'h0);
    chk("t2_valid", 32'(inst_valid), 32'h1);
    chk("t2_pc0", 32'(inst_pc), 32'h00);
    inst_ready = 1'b1;
    @(negedge clk);
    chk("t2_pc1", 32'(inst_pc), 32'h01);
    @(negedge clk);
    chk("t2_pc2", 32'(inst_pc), 32'h02);
    repeat (2) @(negedge clk);

    // Slow memory: request held for three cycles.
    pulse_reset();
    imem_ack = 1'b0; inst_ready = 1'b1;
    release_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_req", 32'(imem_req), 32'h1);
      chk("t3_hold_addr", 32'(imem_addr), 32'h00);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("t3_valid", 32'(inst_valid), 32'h1);
    chk("t3_pc", 32'(inst_pc), 32'h00);
    chk("t3_next_addr", 32'(imem_addr), 32'h01);
    @(negedge clk);
    chk("t3_single_push", 32'(inst_valid), 32'h0);

    // Redirect while the request to 0x03 is pending.
    pulse_reset();
    imem_ack = 1'b1; inst_ready = 1'b1;
    release_reset();
    repeat (4) @(negedge clk);
    chk("t4_addr3", 32'(imem_addr), 32'h03);
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t4_drop_req", 32'(imem_req), 32'h1);
    chk("t4_drop_addr", 32'(imem_addr), 32'h03);
    chk("t4_flushed", 32'(inst_valid), 32'h0);
    @(negedge clk);
    imem_ack = 1'b1;
    @(negedge clk);
    chk("t4_new_addr", 32'(imem_addr), 32'h40);
    chk("t4_no_stale", 32'(inst_valid), 32'h0);
    @(negedge clk);
    chk("t4_pc40", 32'(inst_pc), 32'h40);
    chk("t4_inst40", 32'(instruction), 32'h1A);

    // Redirect coinciding with an ack and a pop.
    pulse_reset();
    imem_ack = 1'b1; inst_ready = 1'b1;
    release_reset();
    repeat (2) @(negedge clk);
    chk("t5_pre_valid", 32'(inst_valid), 32'h1);
    chk("t5_pre_addr", 32'(imem_addr), 32'h01);
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t5_valid_low", 32'(inst_valid), 32'h0);
    chk("t5_addr40", 32'(imem_addr), 32'h40);
    @(negedge clk);
    chk("t5_pc40", 32'(inst_pc), 32'h40);

    // PC wrap after redirect to 0xFF.
    pulse_reset();
    imem_ack = 1'b1; inst_ready = 1'b1;
    release_reset();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 8'hFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t6_addrFF", 32'(imem_addr), 32'hFF);
    @(negedge clk);
    chk("t6_pcFF", 32'(inst_pc), 32'hFF);
    chk("t6_instFF", 32'(instruction), 32'hA5);
    @(negedge clk);
    chk("t6_pc00", 32'(inst_pc), 32'h00);
    @(negedge clk);
    chk("t6_pc01", 32'(inst_pc), 32'h01);

    // Reset asserted while a request is outstanding.
    pulse_reset();
    imem_ack = 1'b1; inst_ready = 1'b0;
    release_reset();
    repeat (2) @(negedge clk);
    imem_ack = 1'b0;
    chk("t7_pre_valid", 32'(inst_valid), 32'h1);
    @(negedge clk);
    chk("t7_pre_req", 32'(imem_req), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("t7_req_drop", 32'(imem_req), 32'h0);
    chk("t7_valid_drop", 32'(inst_valid), 32'h0);
    chk("t7_addr_rst", 32'(imem_addr), 32'h00);
    chk("t7_inst_rst", 32'(instruction), 32'h00);
    chk("t7_pc_rst", 32'(inst_pc), 32'h00);
    @(negedge clk);
    imem_ack = 1'b1; inst_ready = 1'b1;
    release_reset();
    @(negedge clk);
    chk("t7_restart_addr", 32'(imem_addr), 32'h00);
    @(negedge clk);
    chk("t7_restart_pc", 32'(inst_pc), 32'h00);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected end of stimulus");
    $fatal(1, "timeout");
  end

endmodule
